axi4_lite_simple_mst: RTL

Single-outstanding AXI4-Lite master that turns one command from a valid/ready command port into exactly one AXI4-Lite write or read transaction, then returns the result on a valid/ready response port. It sits directly upstream of our AXI4-Lite register slaves and drives them over `axi4_lite_if`. It is the bus driver for register-access sequencers and for simulation benches that do not use a VIP.

---
 rtl/axi4_lite_simple_mst_if.sv | 42 ++++
 rtl/axi4_lite_simple_mst.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/axi4_lite_simple_mst_if.sv
// AXI4-Lite bus bundle shared by the simple master and the register slaves.
// Carries all five channels; PROT is present but fixed to zero by our masters.
interface axi4_lite_if #(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
  logic                                  awvalid;
  logic                                  awready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                            awprot;
  logic                                  wvalid;
  logic                                  wready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                                  bvalid;
  logic                                  bready;
  logic [1:0]                            bresp;
  logic                                  arvalid;
  logic                                  arready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                            arprot;
  logic                                  rvalid;
  logic                                  rready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                            rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slv_port (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axi4_lite_simple_mst.sv
// Single-outstanding AXI4-Lite master: one command in, one bus transaction,
// one response out. Every bus and response output comes straight from a flop.
module axi4_lite_simple_mst #(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_sync_rst,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_is_wr,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic                                  o_rsp_is_wr,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
  axi4_lite_if.mst_port                         if_m_axi4_lite
);
  localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_RSP
  } state_t;

  typedef struct packed {
    logic            awvalid;
    logic            wvalid;
    logic            arvalid;
    logic            bready;
    logic            rready;
    logic [AW-1:0]   awaddr;
    logic [AW-1:0]   araddr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            rsp_valid;
    logic            rsp_is_wr;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
  } out_regs_t;

  state_t    state_q, state_d;
  out_regs_t q, d;

  always_comb begin
    state_d = state_q;
    d       = q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          d.rsp_is_wr = i_cmd_is_wr;
          if (i_cmd_is_wr) begin
            d.awaddr  = i_cmd_addr;
            d.wdata   = i_cmd_wdata;
            d.wstrb   = i_cmd_wstrb;
            d.awvalid = 1'b1;
            d.wvalid  = 1'b1;
            state_d   = ST_WR;
          end else begin
            d.araddr  = i_cmd_addr;
            d.arvalid = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        // AW and W retire independently; a low VALID here means that channel is done.
        d.awvalid = q.awvalid & ~if_m_axi4_lite.awready;
        d.wvalid  = q.wvalid & ~if_m_axi4_lite.wready;
        if (!d.awvalid && !d.wvalid) begin
          d.bready = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (q.bready && if_m_axi4_lite.bvalid) begin
          d.bready    = 1'b0;
          d.rsp_rdata = '0;
          d.rsp_resp  = if_m_axi4_lite.bresp;
          d.rsp_valid = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (q.arvalid && if_m_axi4_lite.arready) begin
          d.arvalid = 1'b0;
          d.rready  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (q.rready && if_m_axi4_lite.rvalid) begin
          d.rready    = 1'b0;
          d.rsp_rdata = if_m_axi4_lite.rdata;
          d.rsp_resp  = if_m_axi4_lite.rresp;
          d.rsp_valid = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          d.rsp_valid = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q <= ST_IDLE;
      q       <= '0;
    end else begin
      state_q <= state_d;
      q       <= d;
    end
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = q.rsp_valid;
  assign o_rsp_is_wr = q.rsp_is_wr;
  assign o_rsp_rdata = q.rsp_rdata;
  assign o_rsp_resp  = q.rsp_resp;

  assign if_m_axi4_lite.awvalid = q.awvalid;
  assign if_m_axi4_lite.awaddr  = q.awaddr;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = q.wvalid;
  assign if_m_axi4_lite.wdata   = q.wdata;
  assign if_m_axi4_lite.wstrb   = q.wstrb;
  assign if_m_axi4_lite.bready  = q.bready;
  assign if_m_axi4_lite.arvalid = q.arvalid;
  assign if_m_axi4_lite.araddr  = q.araddr;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = q.rready;
endmodule
